// File: rtl/score_display_ctrl_if.sv
// Request/status bundle between game logic and the score display controller.
interface score_display_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      add_req;
  logic [3:0]                add_val;
  logic                      clear_req;
  logic                      busy;
  logic                      overflow;
  logic [4*NUM_DIGITS-1:0]   score_bcd;

  modport master (
    output add_req, add_val, clear_req,
    input  busy, overflow, score_bcd
  );

  modport slave (
    input  add_req, add_val, clear_req,
    output busy, overflow, score_bcd
  );
endinterface

// File: rtl/score_display_ctrl.sv
// BCD score keeper with a digit-serial adder and per-pixel glyph scheduling
// for a row of 16x32 digit cells, MSD leftmost.
module score_display_ctrl #(
  parameter int          NUM_DIGITS = 4,
  parameter logic [10:0] TOP_LEFT_X = 11'd16,
  parameter logic [10:0] TOP_LEFT_Y = 11'd16,
  parameter int          CELL_W     = 16,
  parameter int          CELL_H     = 32,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  score_display_ctrl_if.slave        ctl,
  input  logic                       startOfFrame,
  input  logic [10:0]                pixelX,
  input  logic [10:0]                pixelY,
  output logic [3:0]                 digit,
  output logic [10:0]                offsetX,
  output logic [10:0]                offsetY,
  output logic                       InsideRectangle
);

  localparam int          SW       = 4*NUM_DIGITS;
  localparam logic [3:0]  LAST_IDX = 4'(NUM_DIGITS-1);
  localparam logic [10:0] ROW_W    = 11'(CELL_W*NUM_DIGITS);
  localparam logic [10:0] ROW_H    = 11'(CELL_H);
  localparam logic [10:0] X_MASK   = 11'(CELL_W-1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADD = 2'd1, ST_DONE = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [SW-1:0]   score_r, score_s;
  logic [SW-1:0]   disp_r;
  logic [3:0]      addend_r, addend_s;
  logic [3:0]      idx_r, idx_s;
  logic            carry_r, carry_s;
  logic            overflow_r, overflow_s;
  logic            busy_r;
  logic [3:0]      cur_digit_s;
  logic [4:0]      sum_s;
  logic            wrap_s;
  logic [3:0]      new_digit_s;

  logic [10:0]     rel_x_s, rel_y_s;
  logic            in_row_s;
  logic [3:0]      sel_idx_s;
  logic [3:0]      glyph_s;
  logic            blank_s;
  logic            lead_zero_s;

  assign ctl.busy      = busy_r;
  assign ctl.overflow  = overflow_r;
  assign ctl.score_bcd = score_r;

  // Digit currently addressed by the serial adder and its one-digit sum.
  always_comb begin
    cur_digit_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_digit_s = (4'(i) == idx_r) ? score_r[4*i +: 4] : cur_digit_s;
    end
    sum_s       = {1'b0, cur_digit_s} + ((idx_r == 4'd0) ? {1'b0, addend_r} : 5'd0) + {4'd0, carry_r};
    wrap_s      = (sum_s > 5'd9);
    new_digit_s = wrap_s ? 4'(sum_s - 5'd10) : sum_s[3:0];
  end

  // Add/clear FSM next-state logic.
  always_comb begin
    state_s    = state_r;
    score_s    = score_r;
    addend_s   = addend_r;
    idx_s      = idx_r;
    carry_s    = carry_r;
    overflow_s = overflow_r;
    case (state_r)
      ST_IDLE: begin
        if (ctl.clear_req) begin
          score_s    = '0;
          overflow_s = 1'b0;
        end else if (ctl.add_req) begin
          addend_s = (ctl.add_val > 4'd9) ? 4'd9 : ctl.add_val;
          idx_s    = 4'd0;
          carry_s  = 1'b0;
          state_s  = ST_ADD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          score_s[4*i +: 4] = (4'(i) == idx_r) ? new_digit_s : score_r[4*i +: 4];
        end
        carry_s = wrap_s;
        idx_s   = idx_r + 4'd1;
        // Once the carry dies above the LSD the upper digits cannot change.
        if ((idx_r == LAST_IDX) || (!wrap_s && (idx_r != 4'd0))) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ADD;
        end
      end
      ST_DONE: begin
        if (carry_r) begin
          score_s    = {NUM_DIGITS{4'd9}};
          overflow_s = 1'b1;
        end else begin
          overflow_s = overflow_r;
        end
        state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, score and display latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      score_r    <= '0;
      disp_r     <= '0;
      addend_r   <= 4'd0;
      idx_r      <= 4'd0;
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      score_r    <= score_s;
      addend_r   <= addend_s;
      idx_r      <= idx_s;
      carry_r    <= carry_s;
      overflow_r <= overflow_s;
      busy_r     <= (state_s != ST_IDLE);
      // Only latch a settled score so a frame never shows a half-applied add.
      if (startOfFrame && (state_r == ST_IDLE)) begin
        disp_r <= score_r;
      end
    end
  end

  // Cell lookup and leading-zero blanking for the pixel under the beam.
  always_comb begin
    rel_x_s     = pixelX - TOP_LEFT_X;
    rel_y_s     = pixelY - TOP_LEFT_Y;
    in_row_s    = (pixelX >= TOP_LEFT_X) && (rel_x_s < ROW_W) &&
                  (pixelY >= TOP_LEFT_Y) && (rel_y_s < ROW_H);
    sel_idx_s   = LAST_IDX - {1'b0, rel_x_s[6:4]};
    lead_zero_s = 1'b1;
    glyph_s     = 4'd0;
    blank_s     = 1'b0;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      lead_zero_s = lead_zero_s & (disp_r[4*i +: 4] == 4'd0);
      if (4'(i) == sel_idx_s) begin
        glyph_s = disp_r[4*i +: 4];
        blank_s = BLANK_LZ && (i != 0) && lead_zero_s;
      end else begin
        glyph_s = glyph_s;
      end
    end
  end

  // Registered pixel outputs, one clock behind pixelX/pixelY.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit           <= 4'd0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
      InsideRectangle <= 1'b0;
    end else if (in_row_s) begin
      digit           <= glyph_s;
      offsetX         <= rel_x_s & X_MASK;
      offsetY         <= rel_y_s;
      InsideRectangle <= !blank_s;
    end else begin
      digit           <= 4'd0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
      InsideRectangle <= 1'b0;
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: decimal score model plus a
// pixel scoreboard compared one clock after each beam position is driven.
module tb_score_display_ctrl;
  localparam int          N   = 4;
  localparam logic [10:0] TLX = 11'd16;
  localparam logic [10:0] TLY = 11'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = 11'd0;
  logic [10:0] pixelY = 11'd0;
  logic [3:0]  digit;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;

  score_display_ctrl_if #(.NUM_DIGITS(N)) ctl();

  score_display_ctrl #(.NUM_DIGITS(N), .TOP_LEFT_X(TLX), .TOP_LEFT_Y(TLY)) dut (
    .clk(clk), .reset(reset), .ctl(ctl), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .digit(digit), .offsetX(offsetX),
    .offsetY(offsetY), .InsideRectangle(InsideRectangle)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int model_score = 0;
  int model_disp = 0;
  int bc;

  typedef struct {logic [26:0] v; int due; int x; int y;} pix_t;
  pix_t pix_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [26:0] exp_pix(int x, int y, int disp);
    int rx, ry, k, p, d;
    logic [26:0] r;
    r = '0;
    if (x >= int'(TLX) && x < int'(TLX) + 16*N && y >= int'(TLY) && y < int'(TLY) + 32) begin
      rx = x - int'(TLX);
      ry = y - int'(TLY);
      k = N - 1 - rx/16;
      p = 1;
      repeat (k) p = p * 10;
      d = (disp / p) % 10;
      r = {4'(d), 11'(rx % 16), 11'(ry), ((k != 0) && (disp < p)) ? 1'b0 : 1'b1};
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Pixel scoreboard: pop each entry one clock after it was driven.
  always @(negedge clk) begin
    pix_t e;
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      e = pix_q.pop_front();
      tests_run++;
      if ({digit, offsetX, offsetY, InsideRectangle} !== e.v) begin
        tests_failed++;
        $display("FAIL pixel(%0d,%0d): got digit=%0d ox=%0d oy=%0d in=%b, expected digit=%0d ox=%0d oy=%0d in=%b",
                 e.x, e.y, digit, offsetX, offsetY, InsideRectangle,
                 e.v[26:23], e.v[22:12], e.v[11:1], e.v[0]);
      end
    end
  end

  task automatic drive_pix(input int x, input int y);
    pix_t e;
    pixelX = 11'(x);
    pixelY = 11'(y);
    e.v = exp_pix(x, y, model_disp);
    e.due = cyc + 1;
    e.x = x;
    e.y = y;
    pix_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_add(input logic [3:0] v, output int busy_cycles);
    int vv;
    ctl.add_val = v;
    ctl.add_req = 1'b1;
    @(negedge clk);
    ctl.add_req = 1'b0;
    busy_cycles = 0;
    while (ctl.busy === 1'b1 && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    vv = (v > 4'd9) ? 9 : int'(v);
    model_score += vv;
    if (model_score > 9999) model_score = 9999;
  endtask

  task automatic reach(input int target);
    int st, b;
    while (model_score < target) begin
      st = target - model_score;
      do_add(4'((st > 9) ? 9 : st), b);
    end
  endtask

  task automatic frame_pulse();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic do_clear();
    ctl.clear_req = 1'b1;
    @(negedge clk);
    ctl.clear_req = 1'b0;
    model_score = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ctl.busy, ctl.overflow, ctl.score_bcd, digit, offsetX, offsetY, InsideRectangle} !== 45'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b ovf=%b score=%h digit=%0d in=%b, expected all 0",
               ctl.busy, ctl.overflow, ctl.score_bcd, digit, InsideRectangle);
    end
    reset = 1'b0;
    @(negedge clk);
    frame_pulse();
    model_disp = 0;
    for (int c = 0; c < N; c++) drive_pix(int'(TLX) + 16*c + 3, int'(TLY) + 7);
    drive_pix(int'(TLX) - 1, int'(TLY) + 5);
    drive_pix(int'(TLX) + 64, int'(TLY) + 5);
    drive_pix(int'(TLX) + 63, int'(TLY) + 31);
    drive_pix(int'(TLX) + 63, int'(TLY) + 32);
    drive_pix(int'(TLX) + 50, int'(TLY) - 1);
  endtask

  task automatic test_add();
    do_add(4'd7, bc);
    do_add(4'd7, bc);
    frame_pulse();
    model_disp = model_score;
    tests_run++;
    if (ctl.score_bcd !== 16'h0014) begin
      tests_failed++;
      $display("FAIL add_7_7: got %h expected 0014", ctl.score_bcd);
    end
    for (int c = 0; c < N; c++) drive_pix(int'(TLX) + 16*c + 2, int'(TLY) + 10);
    drive_pix(int'(TLX) + 37, int'(TLY) + 5);
    do_add(4'd12, bc);
    tests_run++;
    if (ctl.score_bcd !== 16'h0023) begin
      tests_failed++;
      $display("FAIL add_clamp12: got %h expected 0023", ctl.score_bcd);
    end
    do_add(4'd15, bc);
    tests_run++;
    if (ctl.score_bcd !== 16'h0032) begin
      tests_failed++;
      $display("FAIL add_clamp15: got %h expected 0032", ctl.score_bcd);
    end
  endtask

  task automatic test_carry_chain();
    do_clear();
    reach(999);
    tests_run++;
    if (ctl.score_bcd !== 16'h0999) begin
      tests_failed++;
      $display("FAIL reach_999: got %h expected 0999", ctl.score_bcd);
    end
    do_add(4'd1, bc);
    tests_run++;
    if (bc != 5) begin
      tests_failed++;
      $display("FAIL busy_len_999p1: got %0d expected 5", bc);
    end
    tests_run++;
    if ({ctl.overflow, ctl.score_bcd} !== {1'b0, 16'h1000}) begin
      tests_failed++;
      $display("FAIL result_1000: got ovf=%b score=%h expected ovf=0 score=1000", ctl.overflow, ctl.score_bcd);
    end
  endtask

  task automatic test_overflow();
    reach(9995);
    tests_run++;
    if (ctl.score_bcd !== to_bcd(model_score)) begin
      tests_failed++;
      $display("FAIL reach_9995: got %h expected %h", ctl.score_bcd, to_bcd(model_score));
    end
    do_add(4'd9, bc);
    tests_run++;
    if ({ctl.overflow, ctl.score_bcd} !== {1'b1, 16'h9999} || bc != 5) begin
      tests_failed++;
      $display("FAIL saturate: got ovf=%b score=%h busy=%0d expected ovf=1 score=9999 busy=5",
               ctl.overflow, ctl.score_bcd, bc);
    end
    frame_pulse();
    model_disp = model_score;
    drive_pix(int'(TLX) + 1, int'(TLY) + 1);
    drive_pix(int'(TLX) + 48 + 15, int'(TLY) + 20);
    do_clear();
    tests_run++;
    if ({ctl.overflow, ctl.score_bcd} !== 17'd0) begin
      tests_failed++;
      $display("FAIL clear_after_ovf: got ovf=%b score=%h expected ovf=0 score=0000", ctl.overflow, ctl.score_bcd);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    ctl.add_val = 4'd5;
    ctl.add_req = 1'b1;
    @(negedge clk);
    ctl.add_req = 1'b0;
    tests_run++;
    if (ctl.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_rise: got %b expected 1", ctl.busy);
    end
    ctl.add_val = 4'd3;
    ctl.add_req = 1'b1;
    ctl.clear_req = 1'b1;
    @(negedge clk);
    ctl.add_req = 1'b0;
    ctl.clear_req = 1'b0;
    n = 0;
    while (ctl.busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    model_score = 5;
    tests_run++;
    if ({ctl.busy, ctl.score_bcd} !== {1'b0, 16'h0005}) begin
      tests_failed++;
      $display("FAIL drop_while_busy: got busy=%b score=%h expected busy=0 score=0005", ctl.busy, ctl.score_bcd);
    end
    ctl.add_val = 4'd4;
    ctl.add_req = 1'b1;
    ctl.clear_req = 1'b1;
    @(negedge clk);
    ctl.add_req = 1'b0;
    ctl.clear_req = 1'b0;
    model_score = 0;
    tests_run++;
    if ({ctl.busy, ctl.score_bcd} !== {1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL clear_wins: got busy=%b score=%h expected busy=0 score=0000", ctl.busy, ctl.score_bcd);
    end
  endtask

  task automatic test_hold_and_reset();
    int n;
    do_add(4'd9, bc);
    do_add(4'd5, bc);
    frame_pulse();
    model_disp = model_score;
    ctl.add_val = 4'd7;
    ctl.add_req = 1'b1;
    @(negedge clk);
    ctl.add_req = 1'b0;
    frame_pulse();
    n = 0;
    while (ctl.busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    model_score = 21;
    tests_run++;
    if (ctl.score_bcd !== 16'h0021) begin
      tests_failed++;
      $display("FAIL add_14_7: got %h expected 0021", ctl.score_bcd);
    end
    drive_pix(int'(TLX) + 32 + 4, int'(TLY) + 3);
    drive_pix(int'(TLX) + 48 + 4, int'(TLY) + 3);
    frame_pulse();
    model_disp = model_score;
    drive_pix(int'(TLX) + 32 + 4, int'(TLY) + 3);
    ctl.add_val = 4'd9;
    ctl.add_req = 1'b1;
    @(negedge clk);
    ctl.add_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({ctl.busy, ctl.overflow, ctl.score_bcd} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_add: got busy=%b ovf=%b score=%h expected all 0", ctl.busy, ctl.overflow, ctl.score_bcd);
    end
    reset = 1'b0;
    model_score = 0;
    model_disp = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ctl.busy, ctl.score_bcd} !== 17'd0) begin
      tests_failed++;
      $display("FAIL no_partial_result: got busy=%b score=%h expected busy=0 score=0000", ctl.busy, ctl.score_bcd);
    end
    drive_pix(int'(TLX) + 48 + 9, int'(TLY) + 9);
    drive_pix(int'(TLX) + 32 + 9, int'(TLY) + 9);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl.add_req = 1'b0;
    ctl.add_val = 4'd0;
    ctl.clear_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_carry_chain();
    test_overflow();
    test_back_to_back();
    test_hold_and_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (pix_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", pix_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
